// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, result width and the
// divide-by-zero quotient pattern, plus a magnitude helper for signed operands.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  // Two's-complement magnitude; only applied when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             isSigned);
    return (isSigned && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {rem, q} left, trial-subtract the
// divisor by invert-and-add, and keep the difference only when it does not borrow.
module alu_div_step
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_q,
  output logic             o_borrow
);

  logic [WIDTH:0]   w_remShift;
  logic [WIDTH+1:0] w_trial;
  logic             w_unusedTop;

  // The shifted remainder can reach 33 bits, so the trial runs one bit wider
  // and the top carry decides; a kept difference is below the divisor and fits WIDTH bits.
  assign w_remShift  = {i_rem, i_q[WIDTH-1]};
  assign w_trial     = {1'b0, w_remShift} + {1'b0, ~{1'b0, i_dvs}} + (WIDTH+2)'(1);
  assign o_borrow    = ~w_trial[WIDTH+1];
  assign w_unusedTop = w_trial[WIDTH];

  assign o_rem = o_borrow ? w_remShift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_q   = {i_q[WIDTH-2:0], ~o_borrow};

endmodule

// File: rtl/alu_div32_seq.sv
// Multi-cycle 32-bit restoring divider: one quotient bit per cycle, signed
// operands handled by dividing magnitudes and fixing signs in a final cycle.
module alu_div32_seq
  import alu_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_P-1:0] dividend,
  input  logic [WIDTH_P-1:0] divisor,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_P-1:0] quotient,
  output logic [WIDTH_P-1:0] remainder,
  output logic               div_by_zero
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_qSign;
  logic               r_rSign;
  logic               r_inReady;
  logic               r_outValid;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_nextRem;
  logic [WIDTH-1:0]   w_nextQ;
  logic               w_unusedBorrow;

  alu_div_step u_step (
    .i_rem    (r_rem),
    .i_q      (r_q),
    .i_dvs    (r_dvs),
    .o_rem    (w_nextRem),
    .o_q      (w_nextQ),
    .o_borrow (w_unusedBorrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_qSign     <= 1'b0;
      r_rSign     <= 1'b0;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_inReady <= 1'b0;
            if (divisor == '0) begin
              // Zero divisor skips iteration and reports the raw dividend.
              r_quotient  <= DIV_ZERO_Q;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_outValid  <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_q     <= magnitude(dividend, is_signed);
              r_dvs   <= magnitude(divisor, is_signed);
              r_qSign <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_rSign <= is_signed & dividend[WIDTH-1];
              r_rem   <= '0;
              r_cnt   <= CNT_W'(WIDTH);
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_rem <= w_nextRem;
          r_q   <= w_nextQ;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quotient  <= r_qSign ? (~r_q + WIDTH'(1)) : r_q;
          r_remainder <= r_rSign ? (~r_rem + WIDTH'(1)) : r_rem;
          r_outValid  <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_div32_seq.sv
// Self-checking bench for alu_div32_seq: directed vector table, random
// operations against an arithmetic reference, backpressure and mid-run reset.
module tb_alu_div32_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] expQ;
    logic [31:0] expR;
    logic        expDbz;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  alu_div32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Arithmetic reference: plain division on 64-bit values, truncating toward zero.
  task automatic refModel(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint la, lb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      dbz = 1'b1;
    end else begin
      if (s) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      lq = la / lb;
      lr = la % lb;
      q = lq[31:0];
      r = lr[31:0];
      dbz = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) timeoutFail("in_ready_wait");
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // Cycle count is 1 when out_valid is seen right after the accept edge.
  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) timeoutFail("out_valid_wait");
  endtask

  task automatic releaseResult(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] expQ, input logic [31:0] expR,
                       input logic expDbz, input int expLat, input string tag);
    int lat;
    applyStimulus(a, b, s);
    waitResult(lat);
    if (expLat > 0) checkOutput({tag, "_latency"}, lat, expLat);
    checkOutput({tag, "_quotient"}, quotient, expQ);
    checkOutput({tag, "_remainder"}, remainder, expR);
    checkOutput({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, expDbz});
    releaseResult(tag);
  endtask

  initial begin
    logic [31:0] a, b, eq, er;
    logic        s, ed;
    int          lat;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34});
    vecs.push_back('{32'hFFFF_FF9C,  32'd7,          1'b1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, 34});
    vecs.push_back('{32'd100,        32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFF2,  32'd2,          1'b0, 34});
    vecs.push_back('{32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 34});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 34});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0, 34});
    vecs.push_back('{32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'hFFFF_FFFE,  1'b0, 34});
    vecs.push_back('{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0, 34});
    vecs.push_back('{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0, 34});
    vecs.push_back('{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1});

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_quotient", quotient, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      runOp(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].expQ, vecs[i].expR,
            vecs[i].expDbz, vecs[i].expLat, $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      refModel(a, b, s, eq, er, ed);
      runOp(a, b, s, eq, er, ed, (b == 32'd0) ? 1 : 34, $sformatf("rand%0d", k));
    end

    // Busy-time requests and output backpressure.
    applyStimulus(32'd100, 32'd7, 1'b0);
    for (int k = 0; k < 5; k++) begin
      dividend = 32'd50;
      divisor  = 32'd0;
      in_valid = 1'b1;
      checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    waitResult(lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold_quotient", quotient, 32'd14);
      checkOutput("hold_remainder", remainder, 32'd2);
      checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    checkOutput("hold_dbz", {31'd0, div_by_zero}, 32'd0);
    releaseResult("bp");

    // Reset in the middle of an operation abandons it.
    applyStimulus(32'hFFFF_0000, 32'd3, 1'b0);
    repeat (14) begin
      @(posedge clk); #1;
    end
    checkOutput("midrun_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midreset_quotient", quotient, 32'd0);
    checkOutput("midreset_remainder", remainder, 32'd0);
    checkOutput("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
    runOp(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
